// File: rtl/cnt_sched_pkg.sv
// Shared types and defaults for the cnt_sched round-robin counter scheduler.
package cnt_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        INC  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr wins.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(N_REQ);

    logic found;
    int   j;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                winner   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// Shared-counter job scheduler: round-robin grant, counter steps every 2 clocks to lim.
// Optional abort port/logic enabled by defining CNT_SCHED_ABORT_EN.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   lim,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [CNT_W-1:0]         count,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id
`ifdef CNT_SCHED_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     aborted
`endif
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, winner, pick_idx;
    logic [N_REQ-1:0]   pick_gnt;
    logic [CNT_W-1:0]   lim_q;
    logic               start, abort_go;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (pick_gnt),
        .winner (pick_idx)
    );

    assign start = (state == IDLE) && (|req);

`ifdef CNT_SCHED_ABORT_EN
    assign abort_go = abort && ((state == HOLD) || (state == INC));
`else
    assign abort_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = HOLD;
            HOLD:    state_nxt = (abort_go || count == lim_q) ? DONE : INC;
            INC:     state_nxt = abort_go ? DONE : HOLD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job context is latched only at the grant; req/lim changes mid-job are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= '0;
            winner <= '0;
            lim_q  <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (start) begin
                gnt    <= pick_gnt;
                winner <= pick_idx;
                lim_q  <= lim[int'(pick_idx)*CNT_W +: CNT_W];
                count  <= '0;
            end
            if (state == INC && !abort_go) count <= count + 1'b1;
            if (state == DONE) begin
                gnt    <= '0;
                rr_ptr <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            end
        end
    end

`ifdef CNT_SCHED_ABORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               aborted <= 1'b0;
        else if (abort_go)      aborted <= 1'b1;
        else if (state == DONE) aborted <= 1'b0;
    end
`endif

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign done_id = done ? winner : '0;

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the counter, 2..8.
REQ-002 Parameter CNT_W, default 4: counter width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-low.
REQ-005 Port req  input  N_REQ: per-requester job request, level.
REQ-006 Port lim  input  N_REQ*CNT_W: packed per-requester count limits; slice i is lim[i*CNT_W +: CNT_W].
REQ-007 Port gnt  output  N_REQ: one-hot grant; all-zero when idle.
REQ-008 Port busy  output  1: high whenever the FSM is not in IDLE.
REQ-009 Port count  output  CNT_W: shared counter value.
REQ-010 Port done  output  1: one-cycle pulse at job completion.
REQ-011 Port done_id  output  clog2(N_REQ): index of the completing requester; valid while done=1.
REQ-012 Port abort  input  1: terminate the current job; present only with CNT_SCHED_ABORT_EN.
REQ-013 Port aborted  output  1: qualifies done as an aborted job; present only with CNT_SCHED_ABORT_EN.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, INC and DONE.
REQ-015 IDLE with any req bit set: grant by round-robin starting at rr_ptr; set gnt one-hot; latch winner index and lim slice into lim_q; clear count to 0; go to HOLD.
REQ-016 HOLD: if count==lim_q go to DONE, else go to INC.
REQ-017 INC: count <= count+1; go to HOLD. The counter advances once every 2 clocks.
REQ-018 DONE: done=1 and done_id=winner for exactly this cycle; rr_ptr <= (winner+1) mod N_REQ; go to IDLE.
REQ-019 gnt SHALL stay asserted from the grant edge through the DONE cycle, and clear on the edge leaving DONE.
REQ-020 Latency: with grant at edge E0, DONE is entered at edge E0+2*lim_q+1; lim=0 gives done one cycle after HOLD.
REQ-021 count SHALL hold its final value in IDLE until the next grant; with lim at all-ones it reaches 2^CNT_W-1 and never wraps.
REQ-022 req deassertion or lim change after the grant SHALL be ignored; the job runs to completion.
REQ-023 Requests arriving during HOLD, INC or DONE SHALL wait; at least one IDLE cycle separates consecutive jobs.
REQ-024 Requester i SHALL be granted within N_REQ jobs while its req is held (no starvation).

Reset
REQ-025 Asserting rst low SHALL immediately force: state IDLE, count 0, gnt 0, busy 0, done 0, done_id 0, rr_ptr 0, lim_q 0, aborted 0.
REQ-026 Reset mid-job SHALL discard the job with no done pulse; operation resumes on the first clk edge after rst goes high.

Configuration
REQ-027 Macro CNT_SCHED_ABORT_EN: when defined, abort=1 in HOLD or INC SHALL force DONE on the next edge with count frozen and aborted=1 alongside done; abort is ignored in IDLE and DONE.
REQ-028 Without CNT_SCHED_ABORT_EN, the abort and aborted ports and their logic SHALL be absent, and every job runs to lim_q.

Structure
REQ-029 Package cnt_sched_pkg SHALL hold the state encoding constants (IDLE=2'b00, HOLD=2'b01, INC=2'b10, DONE=2'b11) and the default N_REQ/CNT_W values.
REQ-030 Sub-module rr_pick SHALL be combinational: inputs req and rr_ptr, outputs one-hot grant and winner index.

Verification
REQ-031 Reset release, req=0001, lim0=3 -> gnt=0001; count goes 0,1,2,3; done pulse 7 clocks after the grant edge with done_id=0.
REQ-032 req=1111 held, all lims=1 -> grants in order 0,1,2,3,0; each done_id matches its grant.
REQ-033 lim0=0 -> done one cycle after HOLD, count=0; lim0=15 (CNT_W=4) -> count ends at 15 with no wrap.
REQ-034 rst driven low while count=2 mid-job -> all outputs zero immediately and no done pulse; a new req after release is granted normally.
REQ-035 With CNT_SCHED_ABORT_EN and lim=10, abort pulsed at count=4 -> done=1 and aborted=1 next cycle, count=4; next job starts with rr_ptr advanced.
